clk_freq_meter: RTL and testbench

Measures the frequency of one clock output from the on-board clock wizard against the board reference clock. The clock output is divided down at its source and arrives as meas_in. The block counts rising edges of meas_in over a fixed gate window of reference cycles, then reports the count and whether it is within tolerance of an expected value. A lock flag asserts after several consecutive good windows. It is the consumer/checker for the generated clocks and feeds status LEDs and bring-up logic.

---
 rtl/clk_freq_meter.sv | 149 ++++++++++++++
 tb/tb_clk_freq_meter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts meas_in rising edges over a fixed clk gate window,
// flags the count against an expected value and tracks consecutive-good lock.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int EXPECT      = 125,
  parameter int TOL         = 2,
  parameter int LOCK_N      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             meas_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             locked
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [GW-1:0]           GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W+1)'(EXPECT);
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0]           LOCK_V    = MW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state_q, state_d;

  logic                    sync1_q, sync2_q, prev_q;
  logic [1:0]              arm_q;
  logic [GW-1:0]           gate_q;
  logic [CNT_W-1:0]        edge_q;
  logic                    ovf_q;
  logic [MW-1:0]           match_q;

  logic                    edge_det;
  logic                    arm_done;
  logic                    measuring;
  logic                    win_end;
  logic [CNT_W-1:0]        cnt_nx;
  logic                    ovf_nx;
  logic signed [CNT_W:0]   dev;
  logic signed [CNT_W:0]   dev_abs;
  logic                    win_ok;
  logic [MW-1:0]           match_nx;

  assign edge_det  = sync2_q & ~prev_q;
  assign arm_done  = (arm_q == 2'd2);
  assign measuring = (state_q == MEASURE) && enable;
  assign win_end   = measuring && (gate_q == GATE_LAST);

  // Next count includes the edge seen this cycle, so the final
  // cycle of a window lands in that window's result.
  always_comb begin
    cnt_nx   = edge_q;
    ovf_nx   = ovf_q;
    if (edge_det) begin
      if (edge_q == CNT_MAX) ovf_nx = 1'b1;
      else                   cnt_nx = edge_q + 1'b1;
    end
    dev      = $signed({1'b0, cnt_nx}) - EXP_S;
    dev_abs  = (dev < 0) ? -dev : dev;
    win_ok   = !ovf_nx && (dev_abs <= TOL_S);
    match_nx = '0;
    if (win_ok) begin
      match_nx = (match_q == LOCK_V) ? match_q : match_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ARM;
      ARM: begin
        if (!enable)       state_d = IDLE;
        else if (arm_done) state_d = MEASURE;
      end
      MEASURE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= meas_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q       <= '0;
      gate_q      <= '0;
      edge_q      <= '0;
      ovf_q       <= 1'b0;
      match_q     <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      arm_q <= (state_q == ARM && enable) ? arm_q + 2'd1 : 2'd0;
      if (win_end) begin
        gate_q      <= '0;
        edge_q      <= '0;
        ovf_q       <= 1'b0;
        count       <= cnt_nx;
        overflow    <= ovf_nx;
        in_range    <= win_ok;
        match_q     <= match_nx;
        locked      <= (match_nx == LOCK_V);
        count_valid <= 1'b1;
      end else if (measuring) begin
        gate_q <= gate_q + 1'b1;
        edge_q <= cnt_nx;
        ovf_q  <= ovf_nx;
      end else begin
        gate_q <= '0;
        edge_q <= '0;
        ovf_q  <= 1'b0;
      end
      // Dropping enable discards lock history; count/overflow keep history.
      if (!enable) begin
        match_q  <= '0;
        locked   <= 1'b0;
        in_range <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: randomized-phase stimulus, window-level reference
// model and scoreboard for a 16-bit and an 8-bit counter instance.
module tb_clk_freq_meter;

  localparam int G   = 1000;
  localparam int EXP = 125;
  localparam int TL  = 2;
  localparam int LN  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        meas_in = 1'b0;

  logic [15:0] count16;
  logic        cv16, ir16, ov16, lk16;
  logic [7:0]  count8;
  logic        cv8, ir8, ov8, lk8;

  int period = 8;
  int ph = 0;
  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    int cnt;
    bit ovf;
    bit ir;
    bit lk;
    int t;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  int         p = 0;
  bit         m_idle = 1'b1;
  int         m_a = 0;
  int         m_acc = 0;
  logic [3:0] m_h = '0;
  int         m_mc[2] = '{0, 0};
  int         m_last16 = 0;

  clk_freq_meter #(
    .GATE_CYCLES(G), .CNT_W(16), .EXPECT(EXP), .TOL(TL), .LOCK_N(LN)
  ) u16 (
    .clk(clk), .rst(rst), .enable(enable), .meas_in(meas_in),
    .count(count16), .count_valid(cv16), .in_range(ir16),
    .overflow(ov16), .locked(lk16)
  );

  clk_freq_meter #(
    .GATE_CYCLES(G), .CNT_W(8), .EXPECT(EXP), .TOL(TL), .LOCK_N(LN)
  ) u8 (
    .clk(clk), .rst(rst), .enable(enable), .meas_in(meas_in),
    .count(count8), .count_valid(cv8), .in_range(ir8),
    .overflow(ov8), .locked(lk8)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Window result for each counter width from the raw edge total.
  task automatic push(input int acc);
    exp_t e;
    int mx;
    int d;
    for (int i = 0; i < 2; i++) begin
      mx    = (i == 0) ? 65535 : 255;
      e.cnt = (acc > mx) ? mx : acc;
      e.ovf = (acc > mx);
      d     = e.cnt - EXP;
      if (d < 0) d = -d;
      e.ir  = !e.ovf && (d <= TL);
      m_mc[i] = e.ir ? ((m_mc[i] < LN) ? m_mc[i] + 1 : LN) : 0;
      e.lk  = (m_mc[i] == LN);
      e.t   = p;
      if (i == 0) begin
        q16.push_back(e);
        m_last16 = e.cnt;
      end else begin
        q8.push_back(e);
      end
    end
  endtask

  // An input rising edge driven after clk edge n is counted at edge n+3;
  // windows run G edges each, starting 3 edges after arming.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_idle = 1'b1;
      m_acc  = 0;
      m_h    = '0;
      m_mc[0] = 0;
      m_mc[1] = 0;
    end else begin
      p++;
      m_h = {m_h[2:0], meas_in};
      if (!m_idle && !enable) begin
        m_idle  = 1'b1;
        m_mc[0] = 0;
        m_mc[1] = 0;
      end else if (m_idle && enable) begin
        m_idle = 1'b0;
        m_a    = p;
        m_acc  = 0;
      end else if (!m_idle) begin
        if (m_h[2] && !m_h[3] && p > m_a + 3) m_acc++;
        if (p > m_a + 3 && (p - m_a - 3) % G == 0) begin
          push(m_acc);
          m_acc = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (period == 0) begin
      meas_in = 1'b0;
    end else begin
      ph = (ph + 1) % period;
      meas_in = (ph < period / 2);
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (cv16) begin
        if (q16.size() == 0) begin
          chk("unexpected_pulse16", int'(cv16), 0);
        end else begin
          e = q16.pop_front();
          chk("time16", p, e.t);
          chk("count16", int'(count16), e.cnt);
          chk("overflow16", int'(ov16), int'(e.ovf));
          chk("in_range16", int'(ir16), int'(e.ir));
          chk("locked16", int'(lk16), int'(e.lk));
        end
      end
      if (q16.size() > 0 && q16[0].t < p) begin
        chk("missing_pulse16", p - q16[0].t, 0);
        void'(q16.pop_front());
      end
      if (cv8) begin
        if (q8.size() == 0) begin
          chk("unexpected_pulse8", int'(cv8), 0);
        end else begin
          e = q8.pop_front();
          chk("time8", p, e.t);
          chk("count8", int'(count8), e.cnt);
          chk("overflow8", int'(ov8), int'(e.ovf));
          chk("in_range8", int'(ir8), int'(e.ir));
          chk("locked8", int'(lk8), int'(e.lk));
        end
      end
      if (q8.size() > 0 && q8[0].t < p) begin
        chk("missing_pulse8", p - q8[0].t, 0);
        void'(q8.pop_front());
      end
    end
  end

  task automatic wait_pulse();
    int k = 0;
    @(negedge clk);
    while (!cv16 && k < 2 * G) begin
      @(negedge clk);
      k++;
    end
    chk("pulse_timeout", int'(cv16), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count16"}, int'(count16), 0);
    chk({tag, "_cv16"}, int'(cv16), 0);
    chk({tag, "_ir16"}, int'(ir16), 0);
    chk({tag, "_ov16"}, int'(ov16), 0);
    chk({tag, "_lk16"}, int'(lk16), 0);
    chk({tag, "_count8"}, int'(count8), 0);
    chk({tag, "_ov8"}, int'(ov8), 0);
  endtask

  initial begin
    ph = int'($urandom_range(0, 7));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    @(posedge clk);
    #1 enable = 1'b1;
    repeat (3 + 6 * G + int'($urandom_range(0, 50))) @(posedge clk);
    #1 period = 7;
    repeat (G) @(posedge clk);
    #1 period = 8;
    repeat (5 * G) @(posedge clk);
    #1 period = 0;
    repeat (3 * G) @(posedge clk);
    #1 period = 2;
    repeat (G + int'($urandom_range(0, 100))) @(posedge clk);
    #1 period = 8;
    repeat (6 * G) @(posedge clk);

    wait_pulse();
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("locked_before_abort", int'(lk16), 1);
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cv", int'(cv16), 0);
    chk("abort_locked", int'(lk16), 0);
    chk("abort_in_range", int'(ir16), 0);
    chk("abort_count_hold", int'(count16), m_last16);
    chk("abort_overflow", int'(ov16), 0);
    repeat (50) @(posedge clk);
    #1 enable = 1'b1;
    repeat (5 * G + 100) @(posedge clk);

    wait_pulse();
    repeat (int'($urandom_range(200, 800))) @(posedge clk);
    #5 rst = 1'b1;
    #1 chk_zero("async_rst");
    #2 rst = 1'b0;
    repeat (3 * G + 200) @(posedge clk);

    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain16", q16.size(), 0);
    chk("drain8", q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
